mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one native memory port between the instruction requester (fetch/prefetch) and the data requester (load/store unit).
- Sits between the pipeline's imem/dmem interfaces and the single external memory.
- Data has priority; a starvation counter guarantees fetch progress.
- Latches the granted request, holds it stable until the memory completes, and discards responses for requests the owner abandoned (flush, redirect).

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while a fetch is pending; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_in  in  mem_in_type (70)  fetch request: mem_valid, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0].
- imem_out  out  mem_out_type (33)  fetch response: mem_ready, mem_rdata[31:0].
- dmem_in  in  mem_in_type (70)  data request, same fields.
- dmem_out  out  mem_out_type (33)  data response.
- mem_in  out  mem_in_type (70)  request to shared memory.
- mem_out  in  mem_out_type (33)  response from shared memory.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, starve count=0, abandoned=0, latched request cleared.
  - mem_in all zero; imem_out.mem_ready=0; dmem_out.mem_ready=0.
  - Reset mid-transaction drops the transaction; mem_valid is 0 the cycle after reset.
- States:
  - IDLE: no transaction.
  - BUSY_I: fetch owns the memory.
  - BUSY_D: data owns the memory.
- Arbitration, evaluated in IDLE and in any BUSY cycle where mem_out.mem_ready=1:
  - Data only pending: grant D.
  - Fetch only pending: grant I.
  - Both pending: grant D unless starve count == STARVE_LIMIT, then grant I.
  - Nothing pending: go to or stay in IDLE.
- Grant action:
  - Latch the full request (valid, instr, addr, wdata, wstrb).
  - Move to BUSY_I or BUSY_D at the next edge.
- Starve counter:
  - +1 on each D grant made while fetch is pending, saturating at STARVE_LIMIT.
  - Cleared on every I grant.
  - Cleared when a D grant is made with fetch not pending.
- Memory side, in BUSY:
  - mem_in drives the latched request with mem_valid=1.
  - All fields stay stable until mem_ready=1.
  - In IDLE, mem_valid=0 and the other fields are 0.
- Latency:
  - The request reaches memory 1 cycle after the grant cycle.
  - The response reaches the requester combinationally in the mem_ready cycle.
  - Back-to-back: arbitration in the ready cycle lets the next request be on mem_in the following cycle, with no IDLE bubble.
- Response routing:
  - mem_rdata is broadcast to both outputs.
  - owner.mem_ready = mem_out.mem_ready & ~abandoned & owner_valid_now & (owner_addr_now == latched addr).
  - The non-owner's mem_ready is always 0.
- Abandonment:
  - Set when the owner drops mem_valid or changes mem_addr while BUSY and before ready.
  - The memory transaction still completes; stores are never cut short.
  - The response is discarded (no ready pulse to the requester).
  - abandoned is cleared on the ready cycle.
  - Any new request from that requester is arbitrated normally in the ready cycle.
- Ready cycle with the current request unchanged: the ready pulse is delivered. The requester is expected to present its next request or drop valid in the following cycle.
- Simultaneous events:
  - A new request arriving in the same cycle as the owner's abandonment waits until the ready cycle.
  - mem_ready in IDLE is ignored.
- Writes from imem (wstrb≠0) are passed through unmodified. mem_instr is forwarded from the latched request.

Decomposition:
- constants package: arbiter state encoding (IDLE, BUSY_I, BUSY_D) and the STARVE_LIMIT default.
- wires package:
  - mem_arb_reg_type: state, starve count[3:0], abandoned, latched mem_in_type.
  - init_mem_arb_reg constant.
  - Reuse the existing mem_in_type and mem_out_type.
- Code structure: a single always_comb computing v from r, plus an always_ff register. No sub-module is needed.

Test Plan:
1. Fetch-only: imem addr 0x100, memory ready after 2 cycles with rdata 0x00000013 → mem_addr=0x100 from cycle 1; imem_out.mem_ready=1 with rdata 0x13 in cycle 3; dmem_out.mem_ready stays 0.
2. Simultaneous requests, dmem store addr 0x2000 wstrb 0xF, imem 0x104 → D served first, then I. Memory sees 0x2000 then 0x104 on consecutive transactions with no IDLE cycle between them.
3. Starvation: dmem requests continuously, imem pending, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,...; the counter reads 0 after the I grant.
4. Abandon: fetch 0x200 granted, imem mem_addr changes to 0x300 before ready → mem_addr stays 0x200 until ready, no imem ready pulse for 0x200, then 0x300 is granted and completes with ready=1.
5. Abandoned store: dmem drops valid mid-write to 0x40 → mem_valid and mem_wstrb=0xF held until ready; dmem_out.mem_ready never pulses.
6. Reset in BUSY_D (rst=1 one cycle) → next cycle mem_valid=0, both ready outputs 0, state IDLE, counter 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Request/response bundles match the native memory port layout.
package mem_arbiter_pkg;

   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_t;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic [31:0] mem_rdata;
   } mem_out_type;

   typedef struct packed {
      arb_state_t state;
      logic [3:0] starve;
      logic       abandoned;
      mem_in_type req;
   } mem_arb_reg_type;

   localparam mem_arb_reg_type init_mem_arb_reg = '{
      state:     IDLE,
      starve:    '0,
      abandoned: 1'b0,
      req:       '0
   };

endpackage

// File: rtl/mem_arbiter.sv
// Shares one native memory port between fetch and data requesters.
// Data has priority; a starvation counter bounds how long a fetch can wait.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   output mem_in_type  mem_in,
   input  mem_out_type mem_out
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   mem_arb_reg_type r;
   mem_arb_reg_type v;

   logic        busy;
   logic        owner_valid;
   logic [31:0] owner_addr;
   logic        same_req;
   logic        deliver;
   logic        i_pend;
   logic        d_pend;

   always_comb begin
      v           = r;
      owner_valid = 1'b0;
      owner_addr  = '0;
      case (r.state)
         BUSY_I: begin
            owner_valid = imem_in.mem_valid;
            owner_addr  = imem_in.mem_addr;
         end
         BUSY_D: begin
            owner_valid = dmem_in.mem_valid;
            owner_addr  = dmem_in.mem_addr;
         end
         default: ;
      endcase

      busy     = (r.state != IDLE);
      same_req = owner_valid && (owner_addr == r.req.mem_addr);
      deliver  = busy && mem_out.mem_ready && !r.abandoned && same_req;

      // A request whose response is being delivered right now is complete,
      // so it must not be re-arbitrated in its own ready cycle.
      i_pend = imem_in.mem_valid && !(deliver && (r.state == BUSY_I));
      d_pend = dmem_in.mem_valid && !(deliver && (r.state == BUSY_D));

      if (busy && !mem_out.mem_ready && !same_req) begin
         v.abandoned = 1'b1;
      end

      if (!busy || mem_out.mem_ready) begin
         v.abandoned = 1'b0;
         if (d_pend && (!i_pend || (r.starve != LIMIT))) begin
            v.state  = BUSY_D;
            v.req    = dmem_in;
            v.starve = i_pend ? r.starve + 4'd1 : 4'd0;
         end else if (i_pend) begin
            v.state  = BUSY_I;
            v.req    = imem_in;
            v.starve = '0;
         end else begin
            v.state = IDLE;
            v.req   = '0;
         end
      end

      imem_out.mem_rdata = mem_out.mem_rdata;
      dmem_out.mem_rdata = mem_out.mem_rdata;
      imem_out.mem_ready = deliver && (r.state == BUSY_I);
      dmem_out.mem_ready = deliver && (r.state == BUSY_D);
      mem_in             = r.req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r <= init_mem_arb_reg;
      end else begin
         r <= v;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of the memory arbiter against a bench-side
// memory model, requester models and arbitration rules.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   mem_in_type  imem_in, dmem_in, mem_in;
   mem_out_type imem_out, dmem_out, mem_out;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk      (clk),
      .rst      (rst),
      .imem_in  (imem_in),
      .imem_out (imem_out),
      .dmem_in  (dmem_in),
      .dmem_out (dmem_out),
      .mem_in   (mem_in),
      .mem_out  (mem_out)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        instr;
      int          idle_before;
   } txn_t;

   txn_t        log_q[$];
   int          tests = 0;
   int          fails = 0;
   int          lat = 2;
   bit          m_active = 1'b0;
   int          m_wait = 0;
   mem_in_type  m_cur;
   int          idle_cnt = 0;
   int          i_pulses = 0;
   int          d_pulses = 0;
   bit          i_got = 1'b0;
   bit          d_got = 1'b0;
   int          base, ip0, dp0, i_iss, d_iss;
   logic [31:0] i_seq = '0;
   logic [31:0] d_seq = '0;

   function automatic logic [31:0] resp(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic mem_in_type mk(input logic instr, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] ws);
      mem_in_type q;
      q.mem_valid = 1'b1;
      q.mem_instr = instr;
      q.mem_addr  = a;
      q.mem_wdata = wd;
      q.mem_wstrb = ws;
      return q;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk70(input string tag, input mem_in_type obs, input mem_in_type exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle and run the memory model for the new cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (mem_in.mem_valid) begin
         if (!m_active) begin
            m_active = 1'b1;
            m_wait   = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            m_cur    = mem_in;
            log_q.push_back('{addr: mem_in.mem_addr, wdata: mem_in.mem_wdata,
                              wstrb: mem_in.mem_wstrb, instr: mem_in.mem_instr,
                              idle_before: idle_cnt});
            chk70("start_req", mem_in, mem_in.mem_instr ? imem_in : dmem_in);
         end else begin
            chk70("mem_hold", mem_in, m_cur);
         end
         if (m_wait == 0) begin
            mem_out.mem_ready = 1'b1;
            mem_out.mem_rdata = resp(mem_in.mem_addr);
            m_active = 1'b0;
         end else begin
            m_wait--;
            mem_out.mem_ready = 1'b0;
            mem_out.mem_rdata = $urandom;
         end
      end else begin
         chk70("idle_zero", mem_in, '0);
         m_active = 1'b0;
         idle_cnt++;
         mem_out.mem_ready = 1'($urandom_range(0, 1));
         mem_out.mem_rdata = $urandom;
      end
      if (i_got) begin imem_in.mem_valid = 1'b0; i_got = 1'b0; end
      if (d_got) begin dmem_in.mem_valid = 1'b0; d_got = 1'b0; end
   endtask

   // Let combinational responses settle, then observe the requester side.
   task automatic look();
      #1;
      chk1("ready_excl", imem_out.mem_ready & dmem_out.mem_ready, 1'b0);
      chk32("i_rdata_bcast", imem_out.mem_rdata, mem_out.mem_rdata);
      chk32("d_rdata_bcast", dmem_out.mem_rdata, mem_out.mem_rdata);
      if (imem_out.mem_ready) begin
         i_pulses++;
         i_got = 1'b1;
         chk32("i_rdata", imem_out.mem_rdata, resp(imem_in.mem_addr));
         chk32("i_pulse_addr", mem_in.mem_addr, imem_in.mem_addr);
      end
      if (dmem_out.mem_ready) begin
         d_pulses++;
         d_got = 1'b1;
         chk32("d_rdata", dmem_out.mem_rdata, resp(dmem_in.mem_addr));
         chk32("d_pulse_addr", mem_in.mem_addr, dmem_in.mem_addr);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         cyc();
         look();
      end
   endtask

   // Both requesters stay pending; each retires its request in the ready cycle
   // by presenting a fresh one, so the grant order is purely the priority rule.
   task automatic run_starve(input string tag);
      int b;
      logic exp_i;
      cyc();
      b = log_q.size();
      lat = -1;
      dmem_in = mk(1'b0, 32'h0000_3000, $urandom, 4'h0);
      imem_in = mk(1'b1, 32'h0000_0400, 32'h0, 4'h0);
      look();
      for (int k = 0; k < 300 && log_q.size() < b + 10; k++) begin
         cyc();
         if (mem_out.mem_ready && mem_in.mem_valid) begin
            if (!mem_in.mem_instr && mem_in.mem_addr == dmem_in.mem_addr)
               dmem_in.mem_addr = dmem_in.mem_addr + 32'd4;
            else if (mem_in.mem_instr && mem_in.mem_addr == imem_in.mem_addr)
               imem_in.mem_addr = imem_in.mem_addr + 32'd4;
         end
         look();
      end
      chki({tag, "_ntx"}, log_q.size() - b, 10);
      if (log_q.size() >= b + 10) begin
         for (int j = 0; j < 10; j++) begin
            exp_i = ((j % (LIMIT + 1)) == LIMIT);
            chk1($sformatf("%s_grant%0d", tag, j), log_q[b + j].instr, exp_i);
         end
      end
      cyc();
      imem_in.mem_valid = 1'b0;
      dmem_in.mem_valid = 1'b0;
      look();
      idle_cycles(8);
      chk1({tag, "_drained"}, mem_in.mem_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      imem_in = '0;
      dmem_in = '0;
      mem_out = '0;
      repeat (2) @(posedge clk);
      #1;
      chk70("reset_mem_in", mem_in, '0);
      chk1("reset_i_ready", imem_out.mem_ready, 1'b0);
      chk1("reset_d_ready", dmem_out.mem_ready, 1'b0);
      rst = 1'b0;

      // Fetch only, two-cycle memory latency.
      lat = 2;
      cyc();
      imem_in = mk(1'b1, 32'h0000_0100, 32'h0, 4'h0);
      ip0 = i_pulses;
      look();
      chk1("t1_c0_valid", mem_in.mem_valid, 1'b0);
      cyc(); look();
      chk1("t1_c1_valid", mem_in.mem_valid, 1'b1);
      chk32("t1_c1_addr", mem_in.mem_addr, 32'h0000_0100);
      chk1("t1_c1_iready", imem_out.mem_ready, 1'b0);
      cyc(); look();
      chk1("t1_c2_iready", imem_out.mem_ready, 1'b0);
      cyc(); look();
      chk1("t1_c3_iready", imem_out.mem_ready, 1'b1);
      chk1("t1_c3_dready", dmem_out.mem_ready, 1'b0);
      chk32("t1_c3_rdata", imem_out.mem_rdata, resp(32'h0000_0100));
      cyc(); look();
      chk1("t1_c4_valid", mem_in.mem_valid, 1'b0);
      chki("t1_pulses", i_pulses - ip0, 1);

      // Simultaneous store and fetch: data first, then fetch back-to-back.
      cyc();
      lat = -1;
      base = log_q.size();
      ip0 = i_pulses;
      dp0 = d_pulses;
      dmem_in = mk(1'b0, 32'h0000_2000, $urandom, 4'hF);
      imem_in = mk(1'b1, 32'h0000_0104, 32'h0, 4'h0);
      look();
      for (int k = 0; k < 40 && (i_pulses == ip0 || d_pulses == dp0); k++) begin
         cyc(); look();
      end
      idle_cycles(2);
      chki("t2_ipulse", i_pulses - ip0, 1);
      chki("t2_dpulse", d_pulses - dp0, 1);
      chki("t2_ntx", log_q.size() - base, 2);
      if (log_q.size() >= base + 2) begin
         chk32("t2_first_addr", log_q[base].addr, 32'h0000_2000);
         chk32("t2_first_wstrb", {28'h0, log_q[base].wstrb}, 32'h0000_000F);
         chk32("t2_second_addr", log_q[base + 1].addr, 32'h0000_0104);
         chki("t2_no_bubble", log_q[base + 1].idle_before - log_q[base].idle_before, 0);
      end

      run_starve("t3");

      // Fetch abandoned by an address change before ready.
      cyc();
      lat = 3;
      base = log_q.size();
      ip0 = i_pulses;
      imem_in = mk(1'b1, 32'h0000_0200, 32'h0, 4'h0);
      look();
      cyc();
      chk32("t4_addr", mem_in.mem_addr, 32'h0000_0200);
      imem_in.mem_addr = 32'h0000_0300;
      look();
      for (int k = 0; k < 30 && i_pulses == ip0; k++) begin
         cyc(); look();
      end
      idle_cycles(3);
      chki("t4_pulses", i_pulses - ip0, 1);
      chki("t4_ntx", log_q.size() - base, 2);
      if (log_q.size() >= base + 2) begin
         chk32("t4_tx0", log_q[base].addr, 32'h0000_0200);
         chk32("t4_tx1", log_q[base + 1].addr, 32'h0000_0300);
      end

      // Address leaves and returns: still abandoned, reissued as a new request.
      cyc();
      base = log_q.size();
      ip0 = i_pulses;
      imem_in = mk(1'b1, 32'h0000_0500, 32'h0, 4'h0);
      look();
      cyc(); imem_in.mem_addr = 32'h0000_0600; look();
      cyc(); imem_in.mem_addr = 32'h0000_0500; look();
      for (int k = 0; k < 30 && i_pulses == ip0; k++) begin
         cyc(); look();
      end
      idle_cycles(3);
      chki("t4b_pulses", i_pulses - ip0, 1);
      chki("t4b_ntx", log_q.size() - base, 2);

      // Store abandoned by dropping valid: completes, no response.
      cyc();
      base = log_q.size();
      dp0 = d_pulses;
      dmem_in = mk(1'b0, 32'h0000_0040, $urandom, 4'hF);
      look();
      cyc(); dmem_in.mem_valid = 1'b0; look();
      idle_cycles(8);
      chki("t5_dpulse", d_pulses - dp0, 0);
      chki("t5_ntx", log_q.size() - base, 1);
      if (log_q.size() >= base + 1) begin
         chk32("t5_addr", log_q[base].addr, 32'h0000_0040);
         chk32("t5_wstrb", {28'h0, log_q[base].wstrb}, 32'h0000_000F);
      end
      chk1("t5_idle", mem_in.mem_valid, 1'b0);

      // Reset while data owns the memory.
      cyc();
      lat = 5;
      dmem_in = mk(1'b0, 32'h0000_0080, $urandom, 4'hF);
      look();
      cyc(); look();
      cyc();
      rst = 1'b1;
      dmem_in.mem_valid = 1'b0;
      look();
      cyc();
      rst = 1'b0;
      look();
      chk1("t6_valid", mem_in.mem_valid, 1'b0);
      chk1("t6_iready", imem_out.mem_ready, 1'b0);
      chk1("t6_dready", dmem_out.mem_ready, 1'b0);
      run_starve("t6");

      // Random traffic: every request is served exactly once, in one transaction.
      lat = -1;
      base = log_q.size();
      ip0 = i_pulses;
      dp0 = d_pulses;
      i_iss = 0;
      d_iss = 0;
      for (int c = 0; c < 900; c++) begin
         cyc();
         if (c < 800) begin
            if (!imem_in.mem_valid && $urandom_range(0, 2) == 0) begin
               imem_in = mk(1'b1, 32'h1000_0000 + (i_seq << 2), $urandom, 4'($urandom));
               i_seq = i_seq + 32'd1;
               i_iss++;
            end
            if (!dmem_in.mem_valid && $urandom_range(0, 2) == 0) begin
               dmem_in = mk(1'b0, 32'h2000_0000 + (d_seq << 2), $urandom, 4'($urandom));
               d_seq = d_seq + 32'd1;
               d_iss++;
            end
         end
         look();
      end
      chki("rand_i_served", i_pulses - ip0, i_iss);
      chki("rand_d_served", d_pulses - dp0, d_iss);
      chki("rand_ntx", log_q.size() - base, i_iss + d_iss);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
